am_lock_fsm: RTL and testbench

Per-lane alignment-marker (AM) lock state machine for the 100GbE PCS receive path. It sits directly downstream of the per-lane block-valid and AM pattern-compare stage. It tracks the AM period in valid blocks and declares lock after two consecutive AMs from the same lane at the expected spacing. Once locked, it flags every expected AM position to the deskew/AM-removal stage and drops lock after a configurable run of missing or wrong AMs.

---
 rtl/pcs_am_pkg.sv | 14 +
 rtl/am_period_counter.sv | 31 +++
 rtl/am_lock_fsm.sv | 136 +++++++++++++
 tb/tb_am_lock_fsm.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pcs_am_pkg.sv
// Shared types and defaults for the per-lane alignment-marker lock logic.
package pcs_am_pkg;

    typedef enum logic [1:0] {
        FIND    = 2'd0,
        COUNT_1 = 2'd1,
        LOCKED  = 2'd2
    } am_lock_state_t;

    localparam int AM_PERIOD_DEFAULT      = 16384;
    localparam int N_LANES_DEFAULT        = 20;
    localparam int MAX_INVALID_AM_DEFAULT = 4;

endpackage

// File: rtl/am_period_counter.sv
// Counts valid blocks modulo AM_PERIOD; o_wrap_next marks the block where an AM is due.
module am_period_counter #(
    parameter int AM_PERIOD = 16384,
    parameter int NB_PERIOD = $clog2(AM_PERIOD)
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_load,
    input  logic i_valid,
    output logic o_wrap_next
);

    localparam logic [NB_PERIOD-1:0] LAST = NB_PERIOD'(AM_PERIOD - 1);

    logic [NB_PERIOD-1:0] pcnt;

    // The captured AM block itself loads 0, so the next AM sees AM_PERIOD-1.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pcnt <= '0;
        end else if (i_load) begin
            pcnt <= '0;
        end else if (i_valid) begin
            if (pcnt == LAST) pcnt <= '0;
            else              pcnt <= pcnt + NB_PERIOD'(1);
        end
    end

    assign o_wrap_next = (pcnt == LAST);

endmodule

// File: rtl/am_lock_fsm.sv
// Per-lane AM lock FSM: FIND -> COUNT_1 -> LOCKED, flags expected AM positions once locked.
// Optional bad-AM statistics counter built when AM_LOCK_ERR_CNT_EN is defined.
module am_lock_fsm
    import pcs_am_pkg::*;
#(
    parameter int AM_PERIOD      = AM_PERIOD_DEFAULT,
    parameter int NB_PERIOD      = $clog2(AM_PERIOD),
    parameter int N_LANES        = N_LANES_DEFAULT,
    parameter int NB_LANE_ID     = $clog2(N_LANES),
    parameter int MAX_INVALID_AM = MAX_INVALID_AM_DEFAULT,
    parameter int NB_INVALID     = $clog2(MAX_INVALID_AM + 1)
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_enable,
    input  logic                  i_valid,
    input  logic                  i_am_match,
    input  logic [NB_LANE_ID-1:0] i_am_lane,
    output logic                  o_am_lock,
    output logic [NB_LANE_ID-1:0] o_lane_id,
    output logic                  o_am_flag,
    output logic                  o_resync,
    output logic [1:0]            o_state,
    output logic [15:0]           o_invalid_am_count
);

    // Stream qualifier: i_valid marks a block this cycle; there is no back-pressure,
    // and i_am_match/i_am_lane are only looked at while i_valid is high.

    localparam logic [NB_INVALID-1:0] INV_LAST = NB_INVALID'(MAX_INVALID_AM - 1);

    am_lock_state_t        state;
    logic [NB_INVALID-1:0] inv_cnt;
    logic                  wrap_next;
    logic                  capture;
    logic                  chk;
    logic                  good_am;

    assign capture = i_enable && (state == FIND) && i_valid && i_am_match;
    assign chk     = i_valid && (state != FIND) && wrap_next;
    assign good_am = i_am_match && (i_am_lane == o_lane_id);

    am_period_counter #(
        .AM_PERIOD (AM_PERIOD),
        .NB_PERIOD (NB_PERIOD)
    ) u_period (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_load      (capture),
        .i_valid     (i_valid),
        .o_wrap_next (wrap_next)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= FIND;
            inv_cnt   <= '0;
            o_lane_id <= '0;
            o_am_lock <= 1'b0;
            o_am_flag <= 1'b0;
            o_resync  <= 1'b0;
        end else begin
            o_am_flag <= 1'b0;
            o_resync  <= 1'b0;
            // Disabling is a quiet return to FIND, not a loss-of-lock event.
            if (!i_enable) begin
                state     <= FIND;
                inv_cnt   <= '0;
                o_am_lock <= 1'b0;
            end else begin
                case (state)
                    FIND: begin
                        if (i_valid && i_am_match) begin
                            o_lane_id <= i_am_lane;
                            state     <= COUNT_1;
                        end
                    end
                    COUNT_1: begin
                        if (chk) begin
                            if (good_am) begin
                                state     <= LOCKED;
                                inv_cnt   <= '0;
                                o_am_lock <= 1'b1;
                            end else begin
                                state <= FIND;
                            end
                        end
                    end
                    LOCKED: begin
                        if (chk) begin
                            o_am_flag <= 1'b1;
                            if (good_am) begin
                                inv_cnt <= '0;
                            end else if (inv_cnt == INV_LAST) begin
                                state     <= FIND;
                                inv_cnt   <= '0;
                                o_am_lock <= 1'b0;
                                o_resync  <= 1'b1;
                            end else begin
                                inv_cnt <= inv_cnt + NB_INVALID'(1);
                            end
                        end
                    end
                    default: begin
                        state     <= FIND;
                        inv_cnt   <= '0;
                        o_am_lock <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign o_state = state;

`ifdef AM_LOCK_ERR_CNT_EN
    logic        bad_locked_chk;
    logic [15:0] err_cnt;

    assign bad_locked_chk = i_enable && (state == LOCKED) && chk && !good_am;

    // Saturating; only reset clears it so it survives relock cycles.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            err_cnt <= '0;
        end else if (bad_locked_chk && (err_cnt != 16'hFFFF)) begin
            err_cnt <= err_cnt + 16'd1;
        end
    end

    assign o_invalid_am_count = err_cnt;
`else
    assign o_invalid_am_count = '0;
`endif

endmodule

// File: tb/tb_am_lock_fsm.sv
// Directed bench for am_lock_fsm with AM_PERIOD=8 and MAX_INVALID_AM=4.
module tb_am_lock_fsm;

    localparam int AM_PERIOD      = 8;
    localparam int N_LANES        = 20;
    localparam int NB_LANE_ID     = 5;
    localparam int MAX_INVALID_AM = 4;
`ifdef AM_LOCK_ERR_CNT_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic                  i_clk = 1'b0;
    logic                  i_rst_n = 1'b0;
    logic                  i_enable = 1'b1;
    logic                  i_valid = 1'b0;
    logic                  i_am_match = 1'b0;
    logic [NB_LANE_ID-1:0] i_am_lane = '0;
    logic                  o_am_lock;
    logic [NB_LANE_ID-1:0] o_lane_id;
    logic                  o_am_flag;
    logic                  o_resync;
    logic [1:0]            o_state;
    logic [15:0]           o_invalid_am_count;

    int total = 0;
    int bad   = 0;

    am_lock_fsm #(
        .AM_PERIOD      (AM_PERIOD),
        .N_LANES        (N_LANES),
        .MAX_INVALID_AM (MAX_INVALID_AM)
    ) dut (
        .i_clk              (i_clk),
        .i_rst_n            (i_rst_n),
        .i_enable           (i_enable),
        .i_valid            (i_valid),
        .i_am_match         (i_am_match),
        .i_am_lane          (i_am_lane),
        .o_am_lock          (o_am_lock),
        .o_lane_id          (o_lane_id),
        .o_am_flag          (o_am_flag),
        .o_resync           (o_resync),
        .o_state            (o_state),
        .o_invalid_am_count (o_invalid_am_count)
    );

    always #5 i_clk = ~i_clk;

    // Drive one cycle, then return 1 time unit after the edge so outputs are settled.
    task automatic send(input logic v, input logic m, input logic [NB_LANE_ID-1:0] lane);
        i_valid    = v;
        i_am_match = m;
        i_am_lane  = lane;
        @(posedge i_clk);
        #1;
        i_valid    = 1'b0;
        i_am_match = 1'b0;
        i_am_lane  = '0;
    endtask

    task automatic plain(input int n);
        repeat (n) send(1'b1, 1'b0, '0);
    endtask

    task automatic do_reset();
        i_rst_n    = 1'b0;
        i_enable   = 1'b1;
        i_valid    = 1'b0;
        i_am_match = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
    endtask

    task automatic acquire(input logic [NB_LANE_ID-1:0] lane);
        send(1'b1, 1'b1, lane);
        plain(AM_PERIOD - 1);
        send(1'b1, 1'b1, lane);
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if ({o_am_lock, o_lane_id, o_am_flag, o_resync, o_state, o_invalid_am_count} !== '0) begin
            bad++;
            $display("FAIL reset: lock=%b lane=%0d flag=%b resync=%b state=%0d cnt=%0d want all 0",
                     o_am_lock, o_lane_id, o_am_flag, o_resync, o_state, o_invalid_am_count);
        end
    endtask

    task automatic test_lock_acquire();
        do_reset();
        send(1'b1, 1'b1, 5'd5);
        total++;
        if (o_state !== 2'd1 || o_lane_id !== 5'd5) begin
            bad++;
            $display("FAIL acq_capture: state=%0d lane=%0d want 1/5", o_state, o_lane_id);
        end
        plain(AM_PERIOD - 1);
        total++;
        if (o_state !== 2'd1 || o_am_lock !== 1'b0) begin
            bad++;
            $display("FAIL acq_wait: state=%0d lock=%b want 1/0", o_state, o_am_lock);
        end
        send(1'b1, 1'b1, 5'd5);
        total++;
        if (o_am_lock !== 1'b1 || o_state !== 2'd2 || o_am_flag !== 1'b0) begin
            bad++;
            $display("FAIL acq_lock: lock=%b state=%0d flag=%b want 1/2/0", o_am_lock, o_state, o_am_flag);
        end
        // A mid-period AM is ignored; the next checkpoint still fires at block 16.
        plain(3);
        send(1'b1, 1'b1, 5'd5);
        plain(3);
        total++;
        if (o_am_flag !== 1'b0 || o_state !== 2'd2) begin
            bad++;
            $display("FAIL acq_midam: flag=%b state=%0d want 0/2", o_am_flag, o_state);
        end
        send(1'b1, 1'b1, 5'd5);
        total++;
        if (o_am_flag !== 1'b1 || o_am_lock !== 1'b1) begin
            bad++;
            $display("FAIL acq_flag: flag=%b lock=%b want 1/1", o_am_flag, o_am_lock);
        end
        plain(1);
        total++;
        if (o_am_flag !== 1'b0) begin
            bad++;
            $display("FAIL acq_flag_pulse: flag=%b want 0", o_am_flag);
        end
    endtask

    task automatic test_lane_mismatch();
        do_reset();
        send(1'b1, 1'b1, 5'd5);
        plain(AM_PERIOD - 1);
        send(1'b1, 1'b1, 5'd6);
        total++;
        if (o_state !== 2'd0 || o_am_lock !== 1'b0 || o_lane_id !== 5'd5) begin
            bad++;
            $display("FAIL mismatch_drop: state=%0d lock=%b lane=%0d want 0/0/5", o_state, o_am_lock, o_lane_id);
        end
        plain(AM_PERIOD - 1);
        send(1'b1, 1'b1, 5'd6);
        total++;
        if (o_state !== 2'd1 || o_lane_id !== 5'd6) begin
            bad++;
            $display("FAIL mismatch_recapture: state=%0d lane=%0d want 1/6", o_state, o_lane_id);
        end
        plain(AM_PERIOD - 1);
        send(1'b1, 1'b1, 5'd6);
        total++;
        if (o_am_lock !== 1'b1) begin
            bad++;
            $display("FAIL mismatch_relock: lock=%b want 1", o_am_lock);
        end
    endtask

    task automatic test_loss_of_lock();
        int nflag;
        nflag = 0;
        do_reset();
        acquire(5'd3);
        for (int i = 0; i < 4 * AM_PERIOD; i++) begin
            send(1'b1, 1'b0, '0);
            nflag += int'(o_am_flag);
            if (i == 7 || i == 15 || i == 23) begin
                total++;
                if (o_am_lock !== 1'b1 || o_resync !== 1'b0 || o_am_flag !== 1'b1) begin
                    bad++;
                    $display("FAIL loss_early[%0d]: lock=%b resync=%b flag=%b want 1/0/1",
                             i, o_am_lock, o_resync, o_am_flag);
                end
            end
        end
        total++;
        if (o_resync !== 1'b1 || o_am_lock !== 1'b0 || o_state !== 2'd0 || o_am_flag !== 1'b1) begin
            bad++;
            $display("FAIL loss_drop: resync=%b lock=%b state=%0d flag=%b want 1/0/0/1",
                     o_resync, o_am_lock, o_state, o_am_flag);
        end
        total++;
        if (nflag != 4) begin
            bad++;
            $display("FAIL loss_flags: count=%0d want 4", nflag);
        end
        total++;
        if (o_invalid_am_count !== (ERR_EN ? 16'd4 : 16'd0)) begin
            bad++;
            $display("FAIL loss_stats: cnt=%0d want %0d", o_invalid_am_count, ERR_EN ? 4 : 0);
        end
        plain(1);
        total++;
        if (o_resync !== 1'b0) begin
            bad++;
            $display("FAIL loss_resync_pulse: resync=%b want 0", o_resync);
        end
    endtask

    task automatic test_recovery();
        do_reset();
        acquire(5'd9);
        repeat (3) begin
            plain(AM_PERIOD - 1);
            send(1'b1, 1'b0, '0);
        end
        plain(AM_PERIOD - 1);
        send(1'b1, 1'b1, 5'd9);
        total++;
        if (o_am_lock !== 1'b1 || o_am_flag !== 1'b1 || o_resync !== 1'b0) begin
            bad++;
            $display("FAIL recov_good: lock=%b flag=%b resync=%b want 1/1/0", o_am_lock, o_am_flag, o_resync);
        end
        // Second run of three bad AMs, one of them a different-lane match.
        for (int k = 0; k < 3; k++) begin
            plain(AM_PERIOD - 1);
            if (k == 1) send(1'b1, 1'b1, 5'd10);
            else        send(1'b1, 1'b0, '0);
            total++;
            if (o_am_lock !== 1'b1 || o_state !== 2'd2) begin
                bad++;
                $display("FAIL recov_hold[%0d]: lock=%b state=%0d want 1/2", k, o_am_lock, o_state);
            end
        end
        plain(AM_PERIOD - 1);
        send(1'b1, 1'b0, '0);
        total++;
        if (o_resync !== 1'b1 || o_am_lock !== 1'b0) begin
            bad++;
            $display("FAIL recov_fourth: resync=%b lock=%b want 1/0", o_resync, o_am_lock);
        end
        total++;
        if (o_invalid_am_count !== (ERR_EN ? 16'd7 : 16'd0)) begin
            bad++;
            $display("FAIL recov_stats: cnt=%0d want %0d", o_invalid_am_count, ERR_EN ? 7 : 0);
        end
    endtask

    task automatic test_valid_gaps();
        do_reset();
        send(1'b1, 1'b1, 5'd2);
        plain(3);
        // Match asserted while invalid must be ignored.
        repeat (5) send(1'b0, 1'b1, 5'd2);
        total++;
        if (o_state !== 2'd1 || o_am_lock !== 1'b0) begin
            bad++;
            $display("FAIL gap_hold: state=%0d lock=%b want 1/0", o_state, o_am_lock);
        end
        plain(4);
        total++;
        if (o_state !== 2'd1) begin
            bad++;
            $display("FAIL gap_block7: state=%0d want 1", o_state);
        end
        send(1'b1, 1'b1, 5'd2);
        total++;
        if (o_am_lock !== 1'b1 || o_state !== 2'd2) begin
            bad++;
            $display("FAIL gap_lock: lock=%b state=%0d want 1/2", o_am_lock, o_state);
        end
    endtask

    task automatic test_enable_reset();
        do_reset();
        acquire(5'd7);
        i_enable = 1'b0;
        send(1'b1, 1'b1, 5'd7);
        total++;
        if (o_state !== 2'd0 || o_am_lock !== 1'b0 || o_resync !== 1'b0) begin
            bad++;
            $display("FAIL enable_low: state=%0d lock=%b resync=%b want 0/0/0", o_state, o_am_lock, o_resync);
        end
        send(1'b1, 1'b1, 5'd4);
        total++;
        if (o_state !== 2'd0 || o_lane_id !== 5'd7) begin
            bad++;
            $display("FAIL enable_nocapture: state=%0d lane=%0d want 0/7", o_state, o_lane_id);
        end
        i_enable = 1'b1;
        send(1'b1, 1'b1, 5'd4);
        plain(3);
        total++;
        if (o_state !== 2'd1 || o_lane_id !== 5'd4) begin
            bad++;
            $display("FAIL enable_recapture: state=%0d lane=%0d want 1/4", o_state, o_lane_id);
        end
        #2;
        i_rst_n = 1'b0;
        #1;
        total++;
        if ({o_am_lock, o_lane_id, o_am_flag, o_resync, o_state, o_invalid_am_count} !== '0) begin
            bad++;
            $display("FAIL async_reset: lock=%b lane=%0d flag=%b resync=%b state=%0d cnt=%0d want all 0",
                     o_am_lock, o_lane_id, o_am_flag, o_resync, o_state, o_invalid_am_count);
        end
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        send(1'b1, 1'b1, 5'd11);
        total++;
        if (o_state !== 2'd1 || o_lane_id !== 5'd11) begin
            bad++;
            $display("FAIL post_reset_capture: state=%0d lane=%0d want 1/11", o_state, o_lane_id);
        end
    endtask

    initial begin
        test_reset();
        test_lock_acquire();
        test_lane_mismatch();
        test_loss_of_lock();
        test_recovery();
        test_valid_gaps();
        test_enable_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
